mem_stage: RTL and testbench

MIPS memory-access stage with its MEM/WB pipeline register, directly upstream of the writeback stage.
- Takes EX/MEM control and data.
- Runs a req/ack data-memory transaction for loads and stores, stalling the pipeline while waiting.
- Aligns load data into lane 0.
- Registers datafrommem, datafromimm, wb control, nop_mem and datamask for writeback, which ANDs the load data with datamask and muxes.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 75 +++++++
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MIPS memory-access stage: access sizes, load masks,
// FSM states and the MEM/WB register bundle.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] frommem;
        logic [31:0] fromimm;
        logic [1:0]  wb;
        logic        nop;
        logic [31:0] mask;
        logic [4:0]  rd;
    } mwb_t;

    localparam mwb_t MWB_BUBBLE = '{frommem: 32'h0, fromimm: 32'h0, wb: 2'b00,
                                    nop: 1'b1, mask: 32'h0, rd: 5'h0};

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extraction/masking and store byte-enable/replication.
// LOAD_SIGN_EXT_EN adds sign extension of signed byte/half loads.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] load_mask_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata_i[{lane_i, 3'b000} +: 8];
    assign ld_half = rdata_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        load_data_o = '0;
        load_mask_o = '0;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {24'h0, ld_byte};
                load_mask_o = MASK_BYTE;
            end
            SZ_HALF: begin
                load_data_o = {16'h0, ld_half};
                load_mask_o = MASK_HALF;
            end
            SZ_WORD: begin
                load_data_o = rdata_i;
                load_mask_o = MASK_WORD;
            end
            default: ;
        endcase
`ifdef LOAD_SIGN_EXT_EN
        // Writeback ANDs with the mask, so extended loads must open it fully.
        if (sign_i && size_i == SZ_BYTE) begin
            load_data_o = {{24{ld_byte[7]}}, ld_byte};
            load_mask_o = MASK_WORD;
        end else if (sign_i && size_i == SZ_HALF) begin
            load_data_o = {{16{ld_half[15]}}, ld_half};
            load_mask_o = MASK_WORD;
        end
`endif
    end

`ifndef LOAD_SIGN_EXT_EN
    logic unused_sign;
    assign unused_sign = sign_i;
`endif

    always_comb begin
        be_o    = '0;
        wdata_o = store_data_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            SZ_WORD: be_o = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: req/ack data-memory handshake with timeout plus the MEM/WB register.
// Define LOAD_SIGN_EXT_EN to sign-extend signed byte/half loads.
//
// state | meaning
// IDLE  | accept EX/MEM slot; legal access stalls and launches a request
// BUSY  | dmem_req held until ack or timeout abort
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nop_ex,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [1:0]        wb_in,
    input  logic [4:0]        rd_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_err,
    output logic [31:0]       datafrommem,
    output logic [31:0]       datafromimm,
    output logic [1:0]        wb_out,
    output logic              nop_mem,
    output logic [31:0]       datamask,
    output logic [4:0]        rd_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_err_q;
    mwb_t              mwb_q, mwb_d;

    logic        idle, busy, access, misalign, illegal, timeout_hit;
    logic [31:0] ld_data, ld_mask, st_wdata;
    logic [3:0]  st_be;

    assign idle = (state_q == ST_IDLE);
    assign busy = (state_q == ST_BUSY);

    assign access   = mem_rd ^ mem_wr;
    assign misalign = (mem_size == 2'b11)
                    || (mem_size == SZ_HALF && alu_result[0])
                    || (mem_size == SZ_WORD && alu_result[1:0] != 2'b00);
    assign illegal  = (mem_rd & mem_wr) | (access & misalign);

    // The abort cycle releases stall so upstream advances past the dropped op.
    assign timeout_hit = TO_EN && busy && !dmem_ack && (cnt_q == TO_LAST);

    assign stall = (idle && !nop_ex && access && !illegal)
                 || (busy && !dmem_ack && !timeout_hit);

    mem_lane_align u_align (
        .size_i       (mem_size),
        .lane_i       (alu_result[1:0]),
        .sign_i       (mem_signed),
        .rdata_i      (dmem_rdata),
        .store_data_i (store_data),
        .load_data_o  (ld_data),
        .load_mask_o  (ld_mask),
        .be_o         (st_be),
        .wdata_o      (st_wdata)
    );

    assign dmem_req   = busy;
    assign dmem_we    = busy & mem_wr;
    assign dmem_be    = busy ? st_be : 4'b0000;
    assign dmem_wdata = st_wdata;
    assign dmem_addr  = ADDR_W'({alu_result[31:2], 2'b00});

    always_comb begin
        mwb_d = MWB_BUBBLE;
        if ((idle && !nop_ex && !illegal && !access) || (busy && dmem_ack)) begin
            mwb_d.fromimm = alu_result;
            mwb_d.wb      = wb_in;
            mwb_d.rd      = rd_in;
            mwb_d.nop     = 1'b0;
            mwb_d.mask    = MASK_WORD;
            if (busy && mem_rd) begin
                mwb_d.frommem = ld_data;
                mwb_d.mask    = ld_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            mwb_q     <= MWB_BUBBLE;
        end else begin
            mwb_q     <= mwb_d;
            mem_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!nop_ex) begin
                        if (illegal)
                            mem_err_q <= 1'b1;
                        else if (access)
                            state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (timeout_hit) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        mem_err_q <= 1'b1;
                    end else if (TO_EN) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign mem_err     = mem_err_q;
    assign datafrommem = mwb_q.frommem;
    assign datafromimm = mwb_q.fromimm;
    assign wb_out      = mwb_q.wb;
    assign nop_mem     = mwb_q.nop;
    assign datamask    = mwb_q.mask;
    assign rd_out      = mwb_q.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage, built with TIMEOUT_CYCLES = 4.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        nop_ex, mem_rd, mem_wr, mem_signed, dmem_ack;
    logic [31:0] alu_result, store_data, dmem_rdata;
    logic [1:0]  mem_size, wb_in;
    logic [4:0]  rd_in;
    logic        stall, dmem_req, dmem_we, mem_err, nop_mem;
    logic [31:0] dmem_addr, dmem_wdata, datafrommem, datafromimm, datamask;
    logic [3:0]  dmem_be;
    logic [1:0]  wb_out;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .nop_ex(nop_ex), .alu_result(alu_result),
        .store_data(store_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_signed(mem_signed), .wb_in(wb_in), .rd_in(rd_in), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .mem_err(mem_err), .datafrommem(datafrommem),
        .datafromimm(datafromimm), .wb_out(wb_out), .nop_mem(nop_mem),
        .datamask(datamask), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic nop, input logic [31:0] addr, input logic [31:0] sd,
                          input logic rd_en, input logic wr_en, input logic [1:0] sz,
                          input logic sgn, input logic [1:0] wb, input logic [4:0] rdst);
        nop_ex = nop; alu_result = addr; store_data = sd; mem_rd = rd_en; mem_wr = wr_en;
        mem_size = sz; mem_signed = sgn; wb_in = wb; rd_in = rdst;
    endtask

    task automatic bubble();
        set_op(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0);
    endtask

    initial begin
        bubble();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_nop_mem", {31'h0, nop_mem}, 32'h1);
        check("rst_req", {31'h0, dmem_req}, 32'h0);
        check("rst_err", {31'h0, mem_err}, 32'h0);
        check("rst_mask", datamask, 32'h0);
        check("rst_wb", {30'h0, wb_out}, 32'h0);
        check("rst_be", {28'h0, dmem_be}, 32'h0);
        #9 rst_n = 1'b1;
        tick();

        // Non-memory op
        set_op(1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10, 5'd7);
        #1 check("alu_stall", {31'h0, stall}, 32'h0);
        tick();
        check("alu_imm", datafromimm, 32'h1234_5678);
        check("alu_wb", {30'h0, wb_out}, 32'h2);
        check("alu_nop", {31'h0, nop_mem}, 32'h0);
        check("alu_mask", datamask, 32'hFFFF_FFFF);
        check("alu_rd", {27'h0, rd_out}, 32'd7);
        bubble();
        tick();
        check("bub_nop", {31'h0, nop_mem}, 32'h1);
        check("bub_imm", datafromimm, 32'h0);

        // lbu 0x103, ack in first BUSY cycle
        set_op(1'b0, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b11, 5'd9);
        #1 check("lbu_stall0", {31'h0, stall}, 32'h1);
        check("lbu_req0", {31'h0, dmem_req}, 32'h0);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hAABB_CCDD;
        #1 check("lbu_req1", {31'h0, dmem_req}, 32'h1);
        check("lbu_addr", dmem_addr, 32'h0000_0100);
        check("lbu_we", {31'h0, dmem_we}, 32'h0);
        check("lbu_stall1", {31'h0, stall}, 32'h0);
        check("lbu_nop1", {31'h0, nop_mem}, 32'h1);
        tick();
        dmem_ack = 1'b0; bubble();
        check("lbu_data", datafrommem, 32'h0000_00AA);
        check("lbu_mask", datamask, 32'h0000_00FF);
        check("lbu_nop2", {31'h0, nop_mem}, 32'h0);
        check("lbu_rd", {27'h0, rd_out}, 32'd9);
        check("lbu_req2", {31'h0, dmem_req}, 32'h0);

        // sh 0x202, ack withheld one cycle
        set_op(1'b0, 32'h0000_0202, 32'h0000_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 5'd0);
        #1 check("sh_stall0", {31'h0, stall}, 32'h1);
        tick();
        check("sh_req", {31'h0, dmem_req}, 32'h1);
        check("sh_we", {31'h0, dmem_we}, 32'h1);
        check("sh_addr", dmem_addr, 32'h0000_0200);
        check("sh_be", {28'h0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_stall1", {31'h0, stall}, 32'h1);
        tick();
        dmem_ack = 1'b1;
        #1 check("sh_stall2", {31'h0, stall}, 32'h0);
        tick();
        dmem_ack = 1'b0; bubble();
        check("sh_nop", {31'h0, nop_mem}, 32'h0);
        check("sh_frommem", datafrommem, 32'h0);
        check("sh_imm", datafromimm, 32'h0000_0202);

        // sb lane 1
        set_op(1'b0, 32'h0000_0041, 32'h1234_56A5, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 5'd0);
        tick();
        dmem_ack = 1'b1;
        #1 check("sb_be", {28'h0, dmem_be}, 32'h2);
        check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        check("sb_addr", dmem_addr, 32'h0000_0040);
        tick();
        dmem_ack = 1'b0; bubble();

        // lhu 0x2 with ack
        set_op(1'b0, 32'h0000_0002, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b11, 5'd3);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
        tick();
        dmem_ack = 1'b0; bubble();
        check("lhu_data", datafrommem, 32'h0000_1122);
        check("lhu_mask", datamask, 32'h0000_FFFF);

        // lw misaligned 0x101
        set_op(1'b0, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 5'd4);
        #1 check("mis_stall", {31'h0, stall}, 32'h0);
        check("mis_req0", {31'h0, dmem_req}, 32'h0);
        tick();
        bubble();
        check("mis_err", {31'h0, mem_err}, 32'h1);
        check("mis_nop", {31'h0, nop_mem}, 32'h1);
        check("mis_req1", {31'h0, dmem_req}, 32'h0);
        tick();
        check("mis_err_clr", {31'h0, mem_err}, 32'h0);

        // size 11 is illegal
        set_op(1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b11, 5'd4);
        tick();
        bubble();
        check("sz3_err", {31'h0, mem_err}, 32'h1);

        // ack while idle is ignored
        dmem_ack = 1'b1;
        tick();
        check("idle_ack_req", {31'h0, dmem_req}, 32'h0);
        check("idle_ack_nop", {31'h0, nop_mem}, 32'h1);
        dmem_ack = 1'b0;

        // lw timeout: req 4 cycles, stall released in the last
        set_op(1'b0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 5'd5);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("to_req", {31'h0, dmem_req}, 32'h1);
            check("to_stall", {31'h0, stall}, (k != 3) ? 32'h1 : 32'h0);
            if (k == 3) bubble();
        end
        tick();
        check("to_req_off", {31'h0, dmem_req}, 32'h0);
        check("to_err", {31'h0, mem_err}, 32'h1);
        check("to_nop", {31'h0, nop_mem}, 32'h1);
        check("to_stall_off", {31'h0, stall}, 32'h0);

        // Async reset mid-BUSY
        set_op(1'b0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 5'd5);
        tick();
        check("rb_req", {31'h0, dmem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check("rb_req_drop", {31'h0, dmem_req}, 32'h0);
        check("rb_nop", {31'h0, nop_mem}, 32'h1);
        bubble();
        #2 rst_n = 1'b1;
        tick();

        // lb signed 0x0, rdata 0x80
        set_op(1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b11, 5'd6);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_0080;
        tick();
        dmem_ack = 1'b0; bubble();
`ifdef LOAD_SIGN_EXT_EN
        check("lb_sx_data", datafrommem, 32'hFFFF_FF80);
        check("lb_sx_mask", datamask, 32'hFFFF_FFFF);
`else
        check("lb_zx_data", datafrommem, 32'h0000_0080);
        check("lb_zx_mask", datamask, 32'h0000_00FF);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
